// File: rtl/fetch_pkg.sv
// Shared types and defaults for the fetch stage and its prefetch queue.
// Latency: n/a (types only); backpressure: n/a.
package fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
    } fetch_entry_t;

    // Sequential successor of a word-aligned PC; wraps naturally at 2^32.
    function automatic logic [31:0] next_seq_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry registered prefetch queue; head is read straight from storage.
// Latency: push visible at head one cycle later; flush empties it but keeps a same-cycle push.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       push,
    input  fetch_entry_t               push_data,
    input  logic                       pop,
    output fetch_entry_t               head,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    fetch_entry_t   mem [DEPTH];
    logic [PW-1:0]  rd_ptr;
    logic [PW-1:0]  wr_ptr;
    logic [CW-1:0]  count_q;
    logic [PW-1:0]  wr_idx;

    // A flushing push lands in slot 0 so it becomes the sole, head entry.
    assign wr_idx = flush ? '0 : wr_ptr;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_idx] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= push ? PW'(1) : '0;
            count_q <= push ? CW'(1) : '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    assign head  = mem[rd_ptr];
    assign count = count_q;

endmodule

// File: rtl/stage_fetch_buf.sv
// Sequential instruction fetch feeding decode through a DEPTH-entry prefetch queue; FETCH_BYPASS_EN adds an empty-queue bypass.
// Latency: ack->decode 1 cycle (0 with bypass on an empty queue); keeps fetching under decode stall until full.
module stage_fetch_buf
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          DEPTH    = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       de_stall,
    input  logic                       de_setpc,
    input  logic [31:0]                de_newpc,
    output logic                       fe_req,
    output logic [31:0]                fe_addr,
    input  logic                       fe_ack,
    input  logic [31:0]                fe_data,
    output logic                       de_valid,
    output logic [31:0]                de_pc,
    output logic [31:0]                de_insn,
    output logic [$clog2(DEPTH+1)-1:0] fe_count
);

    localparam int CW = $clog2(DEPTH+1);

    logic [31:0]   fe_pc;
    logic [CW-1:0] count;
    logic          full;
    logic          push;
    logic          pop;
    logic          fifo_push;
    logic          fifo_pop;
    logic          bypass_hit;
    fetch_entry_t  head;
    fetch_entry_t  push_entry;

    assign full    = (count == CW'(DEPTH));
    assign fe_addr = de_setpc ? de_newpc : fe_pc;

`ifdef FETCH_BYPASS_EN
    // Empty queue: the returning word goes straight to decode in the ack cycle.
    assign bypass_hit = (count == '0) & fe_ack & ~de_setpc;
    assign de_valid   = (count != '0) | bypass_hit;
    assign de_pc      = bypass_hit ? fe_addr : head.pc;
    assign de_insn    = bypass_hit ? fe_data : head.insn;
`else
    assign bypass_hit = 1'b0;
    assign de_valid   = (count != '0);
    assign de_pc      = head.pc;
    assign de_insn    = head.insn;
`endif

    assign pop    = de_valid & ~de_stall & ~de_setpc;
    // A full queue still fetches when the head leaves this cycle.
    assign fe_req = de_setpc | ~full | pop;
    assign push   = fe_req & fe_ack;

    // A bypassed word consumed by decode never occupies a slot.
    assign fifo_push = push & ~(bypass_hit & ~de_stall);
    assign fifo_pop  = pop & ~bypass_hit;

    assign push_entry.pc   = fe_addr;
    assign push_entry.insn = fe_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            fe_pc <= RESET_PC;
        end else if (push) begin
            fe_pc <= next_seq_pc(fe_addr);
        end else if (de_setpc) begin
            fe_pc <= de_newpc;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (de_setpc),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .head      (head),
        .count     (count)
    );

    assign fe_count = count;

endmodule

// File: tb/tb_stage_fetch_buf.sv
// Directed + random bench for stage_fetch_buf with a queue-based expected-instruction scoreboard.
module tb_stage_fetch_buf;
    import fetch_pkg::*;

    localparam int          DEPTH = 4;
    localparam int          CW    = $clog2(DEPTH+1);
    localparam logic [31:0] RPC   = 32'h8000_0000;

    logic          clk;
    logic          reset;
    logic          de_stall;
    logic          de_setpc;
    logic [31:0]   de_newpc;
    logic          fe_req;
    logic [31:0]   fe_addr;
    logic          fe_ack;
    logic [31:0]   fe_data;
    logic          de_valid;
    logic [31:0]   de_pc;
    logic [31:0]   de_insn;
    logic [CW-1:0] fe_count;

    int checks = 0;
    int errors = 0;

    fetch_entry_t q[$];
    logic [31:0]  m_pc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_2468;
    endfunction

    assign fe_data = mem_word(fe_addr);

    stage_fetch_buf #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .de_stall (de_stall),
        .de_setpc (de_setpc),
        .de_newpc (de_newpc),
        .fe_req   (fe_req),
        .fe_addr  (fe_addr),
        .fe_ack   (fe_ack),
        .fe_data  (fe_data),
        .de_valid (de_valid),
        .de_pc    (de_pc),
        .de_insn  (de_insn),
        .fe_count (fe_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus: drive, compare against the model mid-cycle, clock, update model.
    task automatic step(input logic st, input logic sp, input logic [31:0] np,
                        input logic ak, input logic rs);
        logic [31:0]  m_addr;
        logic         m_byp, m_valid, m_pop, m_req, m_push;
        fetch_entry_t m_head, e;
        de_stall = st; de_setpc = sp; de_newpc = np; fe_ack = ak; reset = rs;
        #3;
        m_addr = sp ? np : m_pc;
        m_byp  = 1'b0;
`ifdef FETCH_BYPASS_EN
        m_byp  = (q.size() == 0) && ak && !sp;
`endif
        e.pc   = m_addr;
        e.insn = mem_word(m_addr);
        m_valid = (q.size() != 0) || m_byp;
        m_head  = m_byp ? e : ((q.size() != 0) ? q[0] : '0);
        m_pop   = m_valid && !st && !sp;
        m_req   = sp || (q.size() < DEPTH) || m_pop;
        m_push  = m_req && ak;
        if (!rs) begin
            check("fe_req", 32'(fe_req), 32'(m_req));
            check("fe_addr", fe_addr, m_addr);
            check("de_valid", 32'(de_valid), 32'(m_valid));
            check("fe_count", 32'(fe_count), 32'(q.size()));
            if (m_valid) begin
                check("de_pc", de_pc, m_head.pc);
                check("de_insn", de_insn, m_head.insn);
            end
        end
        @(posedge clk);
        #1;
        if (rs) begin
            q.delete();
            m_pc = RPC;
        end else begin
            if (sp) q.delete();
            else if (m_pop && !m_byp) void'(q.pop_front());
            if (m_push && !(m_byp && !st)) q.push_back(e);
            if (m_push) m_pc = m_addr + 32'd4;
            else if (sp) m_pc = np;
        end
    endtask

    // Look at state with no ack or redirect so outputs depend only on registered state.
    task automatic peek(input logic st);
        de_stall = st; de_setpc = 1'b0; fe_ack = 1'b0; reset = 1'b0;
        #2;
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    endtask

    initial begin
        reset = 1'b1; de_stall = 1'b0; de_setpc = 1'b0; de_newpc = '0; fe_ack = 1'b0;
        m_pc = RPC;
        @(posedge clk); #1;
        do_reset();

        peek(1'b0);
        check("rst_valid", 32'(de_valid), 32'd0);
        check("rst_count", 32'(fe_count), 32'd0);
        check("rst_req", 32'(fe_req), 32'd1);
        check("rst_addr", fe_addr, RPC);

        // Streaming with continuous ack.
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);

        // Decode stall fills the queue.
        do_reset();
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        peek(1'b1);
        check("full_count", 32'(fe_count), 32'(DEPTH));
        check("full_req", 32'(fe_req), 32'd0);
        check("full_depc", de_pc, RPC);
        check("full_addr", fe_addr, 32'h8000_0010);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);

        // Full queue with pop and push together.
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        peek(1'b1);
        check("fullpop_count", 32'(fe_count), 32'(DEPTH));

        // Redirect with three entries queued.
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        peek(1'b1);
        check("pre_redir_count", 32'(fe_count), 32'd3);
        step(1'b0, 1'b1, 32'h8000_0100, 1'b1, 1'b0);
        peek(1'b1);
        check("redir_count", 32'(fe_count), 32'd1);
        check("redir_depc", de_pc, 32'h8000_0100);
        check("redir_addr", fe_addr, 32'h8000_0104);

        // Memory withholds ack.
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        peek(1'b0);
        check("gap_valid", 32'(de_valid), 32'd0);
        check("gap_addr", fe_addr, 32'h8000_0104);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);

        // Reset pulse with two entries queued.
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        peek(1'b1);
        check("pre_rst_count", 32'(fe_count), 32'd2);
        step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
        peek(1'b1);
        check("midrst_valid", 32'(de_valid), 32'd0);
        check("midrst_addr", fe_addr, RPC);
        check("midrst_count", 32'(fe_count), 32'd0);

        // Address wrap at the top of the address space.
        step(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0);
        peek(1'b1);
        check("wrap_addr", fe_addr, 32'h0000_0000);
        check("wrap_depc", de_pc, 32'hFFFF_FFFC);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0,
                 $urandom() & 32'hFFFF_FFFC, $urandom_range(0, 3) != 0, 1'b0);
        end
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        peek(1'b0);
        check("final_empty", 32'(de_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
